core_regfile_sb: RTL and testbench
==================================

// Module: core_regfile_sb
// PURPOSE
// - Parametrised multi-port integer register file with an integrated busy-register scoreboard.
// - Sits between the RD stage (read ports, claim at issue) and the WB stage (write ports).
// - Speaks core::rf_read_req_t / rf_read_rsp_t and rf_write_req_t / rf_write_rsp_t.
// - Adds over the single-port register file: N read and M write ports, same-cycle write bypass,
//   and per-register pending-write tracking, reported through rsp.valid.
// PARAMETERS
// - NUM_RD     2   number of read ports (1..4)
// - NUM_WR     1   number of write ports (1..2)
// - REG_COUNT  32  architectural registers; x0 is hardwired to zero
// - REG_WIDTH  32  data width of each register
// - BYPASS     1   1: a same-cycle write is forwarded to reads. 0: reads see the pre-write value.
// PORTS
// - clk         in   1                  core clock, rising edge
// - rst_n       in   1                  asynchronous, active-low reset
// - rd_req_i    in   NUM_RD x rf_read_req_t   read requests: addr, en
// - rd_rsp_o    out  NUM_RD x rf_read_rsp_t   read responses: data, valid, done
// - wr_req_i    in   NUM_WR x rf_write_req_t  write requests: addr, data, en
// - wr_rsp_o    out  NUM_WR x rf_write_rsp_t  write responses: valid, done
// - claim_en_i  in   1                  reserve claim_rd_i as having a pending writer
// - claim_rd_i  in   5                  destination register being claimed
// - flush_i     in   1                  clear all busy bits; register contents are kept
// - busy_o      out  REG_COUNT          current scoreboard, bit i = register i pending
// BEHAVIOUR
// - Reset (rst_n=0, async): all registers=0, busy=0, every rd_rsp_o and wr_rsp_o='0.
// - Read, latency 1:
//   - rd_req.en sampled at edge k.
//   - At k+1: done=1, data=reg value, valid=!busy[addr] evaluated at edge k.
//   - When en=0: done=0, valid=0, data holds its last value.
// - Read addr 0: data=0, valid=1, always.
// - BYPASS=1: when a write port writes addr A in the same cycle a read of A is sampled:
//   - data = the write data;
//   - valid=1, unless a claim to A is also accepted in that cycle, in which case valid=0.
// - Write:
//   - wr_req.en with addr!=0 updates the register at the edge.
//   - wr_rsp done=1 and valid=1 at the next cycle.
//   - Write to addr 0 is discarded; the port still reports done=1, valid=1.
// - Write collision (NUM_WR>1, same addr, both en):
//   - the highest-index port wins;
//   - each losing port reports done=1, valid=0.
// - Scoreboard, per edge, in priority order:
//   - flush_i: busy <= 0. Any claim in that cycle is ignored; writes still commit.
//   - Otherwise, an accepted write to A clears busy[A].
//   - Then claim_en_i sets busy[claim_rd_i]. When claim and write hit the same register,
//     the claim wins and the bit stays 1 (a new producer exists).
// - claim_rd_i=0 is ignored; busy[0] is constant 0.
// - Claiming an already-busy register is legal and leaves the bit set. No counting; WAW is
//   serialised upstream.
// - busy_o is registered; no combinational path from the inputs.
// - Reset asserted mid-operation: every response in flight is dropped; outputs are '0
//   immediately.
// - No other combinational paths: every output is driven from flops.
// STRUCTURE
// - Add to package core:
//   - rf_claim_req_t {reg_addr_t reg_addr; bool en;}
//   - typedef logic [rv32i::reg_count-1:0] rf_busy_t
//   - localparam rf_busy_t rf_busy_rst='0
// - Sub-module core_rf_scoreboard:
//   - inputs: claim, write-commit vector, flush;
//   - outputs: busy vector and the busy-next used for bypass validity.
// - Data array, bypass muxing and the response registers stay in core_regfile_sb.
// TESTING
// - Reset, then read x5 on port 0 -> next cycle done=1, valid=1, data=0. busy_o=0.
// - Write x5=0xDEADBEEF; read x5 in the next cycle -> data=0xDEADBEEF, valid=1.
//   Write x0=0x1234, then read x0 -> data=0, valid=1.
// - Claim x7, read x7 the next cycle -> valid=0 and busy_o[7]=1.
//   Then write x7=0x55 with a read of x7 in the same cycle (BYPASS=1) -> data=0x55, valid=1,
//   and busy_o[7]=0 afterwards.
// - Same cycle, claim x9 and write x9=0xA -> busy_o[9]=1 and x9=0xA.
//   Flush -> busy_o=0, x9 still reads 0xA.
// - NUM_WR=2, both ports write x3 (0x11 on port 0, 0x22 on port 1)
//   -> x3=0x22; wr_rsp[0] done=1 valid=0; wr_rsp[1] done=1 valid=1.
// - Drop rst_n mid-cycle while a read is pending -> rd_rsp_o='0 immediately,
//   and all registers read 0 after release.

Source files
------------

// File: rtl/core_regfile_sb_pkg.sv
// Shared types for the multi-port register file and its busy-register scoreboard.
package core_regfile_sb_pkg;

  localparam int unsigned RegCount = 32;
  localparam int unsigned Xlen     = 32;

  typedef logic [$clog2(RegCount)-1:0] reg_addr_t;
  typedef logic [Xlen-1:0]             reg_data_t;
  typedef logic [RegCount-1:0]         rf_busy_t;

  localparam rf_busy_t rf_busy_rst = '0;

  typedef struct packed {
    reg_addr_t addr;
    logic      en;
  } rf_read_req_t;

  typedef struct packed {
    reg_data_t data;
    logic      valid;
    logic      done;
  } rf_read_rsp_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
    logic      en;
  } rf_write_req_t;

  typedef struct packed {
    logic valid;
    logic done;
  } rf_write_rsp_t;

  typedef struct packed {
    reg_addr_t reg_addr;
    logic      en;
  } rf_claim_req_t;

  function automatic rf_busy_t addr_onehot(reg_addr_t a);
    rf_busy_t m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/core_rf_scoreboard.sv
// Busy-register scoreboard: per-register pending-writer bits, flush > write-clear < claim.
module core_rf_scoreboard
  import core_regfile_sb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  rf_claim_req_t claim_i,
  input  rf_busy_t      commit_i,
  input  logic          flush_i,
  output rf_busy_t      busy_o,
  output rf_busy_t      busy_next_o
);

  rf_busy_t r_busy;
  rf_busy_t w_busy_next;

  always_comb begin
    w_busy_next = r_busy & ~commit_i;
    // A claim landing on the register being written names a newer producer.
    if (claim_i.en && (claim_i.reg_addr != '0)) begin
      w_busy_next = w_busy_next | addr_onehot(claim_i.reg_addr);
    end
    if (flush_i) begin
      w_busy_next = rf_busy_rst;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= rf_busy_rst;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign busy_o      = r_busy;
  assign busy_next_o = w_busy_next;

endmodule

// File: rtl/core_regfile_sb.sv
// Multi-port integer register file with write bypass and integrated busy scoreboard.
module core_regfile_sb
  import core_regfile_sb_pkg::*;
#(
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_WR    = 1,
  parameter int unsigned REG_COUNT = RegCount,
  parameter int unsigned REG_WIDTH = Xlen,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  rf_read_req_t  [NUM_RD-1:0] rd_req_i,
  output rf_read_rsp_t  [NUM_RD-1:0] rd_rsp_o,
  input  rf_write_req_t [NUM_WR-1:0] wr_req_i,
  output rf_write_rsp_t [NUM_WR-1:0] wr_rsp_o,
  input  logic                       claim_en_i,
  input  reg_addr_t                  claim_rd_i,
  input  logic                       flush_i,
  output rf_busy_t                   busy_o
);

  logic [REG_WIDTH-1:0] r_regs [REG_COUNT];
  rf_read_rsp_t  [NUM_RD-1:0] r_rd_rsp;
  rf_write_rsp_t [NUM_WR-1:0] r_wr_rsp;

  logic          [NUM_WR-1:0] w_wr_win;
  rf_busy_t                   w_commit;
  rf_busy_t                   w_busy;
  rf_busy_t                   w_busy_next;
  rf_claim_req_t              w_claim;
  reg_data_t     [NUM_RD-1:0] w_rd_data;
  logic          [NUM_RD-1:0] w_rd_valid;

  assign w_claim = '{reg_addr: claim_rd_i, en: claim_en_i};

  // On an address collision the highest-index enabled port wins.
  always_comb begin
    w_wr_win = '0;
    w_commit = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      w_wr_win[j] = wr_req_i[j].en;
      for (int unsigned k = j + 1; k < NUM_WR; k++) begin
        if (wr_req_i[k].en && (wr_req_i[k].addr == wr_req_i[j].addr)) begin
          w_wr_win[j] = 1'b0;
        end
      end
      if (w_wr_win[j] && (wr_req_i[j].addr != '0)) begin
        w_commit = w_commit | addr_onehot(wr_req_i[j].addr);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      w_rd_data[i]  = r_regs[rd_req_i[i].addr];
      w_rd_valid[i] = ~w_busy[rd_req_i[i].addr];
      if (BYPASS) begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (w_wr_win[j] && (wr_req_i[j].addr == rd_req_i[i].addr)) begin
            w_rd_data[i]  = wr_req_i[j].data;
            w_rd_valid[i] = ~w_busy_next[rd_req_i[i].addr];
          end
        end
      end
      if (rd_req_i[i].addr == '0) begin
        w_rd_data[i]  = '0;
        w_rd_valid[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs   <= '{default: '0};
      r_rd_rsp <= '0;
      r_wr_rsp <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (w_wr_win[j] && (wr_req_i[j].addr != '0)) begin
          r_regs[wr_req_i[j].addr] <= wr_req_i[j].data;
        end
        r_wr_rsp[j].done  <= wr_req_i[j].en;
        r_wr_rsp[j].valid <= w_wr_win[j];
      end
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        r_rd_rsp[i].done  <= rd_req_i[i].en;
        r_rd_rsp[i].valid <= rd_req_i[i].en & w_rd_valid[i];
        if (rd_req_i[i].en) begin
          r_rd_rsp[i].data <= w_rd_data[i];
        end
      end
    end
  end

  core_rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .claim_i    (w_claim),
    .commit_i   (w_commit),
    .flush_i    (flush_i),
    .busy_o     (w_busy),
    .busy_next_o(w_busy_next)
  );

  assign rd_rsp_o = r_rd_rsp;
  assign wr_rsp_o = r_wr_rsp;
  assign busy_o   = w_busy;

endmodule

// File: tb/tb_core_regfile_sb.sv
// Directed plus randomized bench for core_regfile_sb against a behavioural register-file model.
module tb_core_regfile_sb;
  import core_regfile_sb_pkg::*;

  localparam int unsigned NRd = 2;
  localparam int unsigned NWr = 2;

  logic clk;
  logic rst_n;
  rf_read_req_t  [NRd-1:0] rd_req;
  rf_read_rsp_t  [NRd-1:0] rd_rsp;
  rf_write_req_t [NWr-1:0] wr_req;
  rf_write_rsp_t [NWr-1:0] wr_rsp;
  logic      claim_en;
  reg_addr_t claim_rd;
  logic      flush;
  rf_busy_t  busy;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [31:0]   m_regs [32];
  logic [31:0]   m_busy;
  rf_read_rsp_t  [NRd-1:0] exp_rd;
  rf_write_rsp_t [NWr-1:0] exp_wr;

  core_regfile_sb #(
    .NUM_RD   (NRd),
    .NUM_WR   (NWr),
    .REG_COUNT(32),
    .REG_WIDTH(32),
    .BYPASS   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req_i  (rd_req),
    .rd_rsp_o  (rd_rsp),
    .wr_req_i  (wr_req),
    .wr_rsp_o  (wr_rsp),
    .claim_en_i(claim_en),
    .claim_rd_i(claim_rd),
    .flush_i   (flush),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_req   = '0;
    wr_req   = '0;
    claim_en = 1'b0;
    claim_rd = '0;
    flush    = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_busy = '0;
    exp_rd = '0;
    exp_wr = '0;
  endtask

  // Apply current inputs for one clock, advance the model, then compare everything.
  task automatic cycle();
    logic        hit;
    logic        claim_ok;
    logic        lose;
    logic [31:0] d;
    int          a;
    claim_ok = claim_en && !flush && (claim_rd != 0);
    for (int i = 0; i < NRd; i++) begin
      if (rd_req[i].en) begin
        a   = int'(rd_req[i].addr);
        hit = 1'b0;
        d   = m_regs[a];
        for (int j = 0; j < NWr; j++) begin
          if (wr_req[j].en && int'(wr_req[j].addr) == a) begin
            hit = 1'b1;
            d   = wr_req[j].data;
          end
        end
        exp_rd[i].done = 1'b1;
        if (a == 0) begin
          exp_rd[i].data  = '0;
          exp_rd[i].valid = 1'b1;
        end else if (hit) begin
          exp_rd[i].data  = d;
          exp_rd[i].valid = !(claim_ok && int'(claim_rd) == a);
        end else begin
          exp_rd[i].data  = d;
          exp_rd[i].valid = !m_busy[a];
        end
      end else begin
        exp_rd[i].done  = 1'b0;
        exp_rd[i].valid = 1'b0;
      end
    end
    for (int j = 0; j < NWr; j++) begin
      lose = 1'b0;
      for (int k = j + 1; k < NWr; k++) begin
        if (wr_req[k].en && wr_req[k].addr == wr_req[j].addr) lose = 1'b1;
      end
      exp_wr[j].done  = wr_req[j].en;
      exp_wr[j].valid = wr_req[j].en && !lose;
    end
    for (int j = 0; j < NWr; j++) begin
      if (wr_req[j].en && wr_req[j].addr != 0) m_regs[int'(wr_req[j].addr)] = wr_req[j].data;
    end
    if (flush) begin
      m_busy = '0;
    end else begin
      for (int j = 0; j < NWr; j++) begin
        if (wr_req[j].en && wr_req[j].addr != 0) m_busy[int'(wr_req[j].addr)] = 1'b0;
      end
      if (claim_ok) m_busy[int'(claim_rd)] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NRd; i++) chk($sformatf("rd_rsp[%0d]", i), 64'(rd_rsp[i]), 64'(exp_rd[i]));
    for (int j = 0; j < NWr; j++) chk($sformatf("wr_rsp[%0d]", j), 64'(wr_rsp[j]), 64'(exp_wr[j]));
    chk("busy", 64'(busy), 64'(m_busy));
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    model_reset();
    rst_n = 1'b0;
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rd0", 64'(rd_rsp[0]), 64'd0);
    chk("reset_wr1", 64'(wr_rsp[1]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Read after reset
    rd_req[0] = '{addr: 5'd5, en: 1'b1};
    cycle();
    chk("x5_reset_data", 64'(rd_rsp[0].data), 64'd0);
    chk("x5_reset_vd", 64'({rd_rsp[0].valid, rd_rsp[0].done}), 64'b11);

    // Write then read back; x0 discards writes
    idle(); wr_req[0] = '{addr: 5'd5, data: 32'hDEADBEEF, en: 1'b1}; cycle();
    idle(); rd_req[0] = '{addr: 5'd5, en: 1'b1}; cycle();
    chk("x5_data", 64'(rd_rsp[0].data), 64'hDEADBEEF);
    idle(); wr_req[0] = '{addr: 5'd0, data: 32'h1234, en: 1'b1}; cycle();
    chk("x0_wr_vd", 64'({wr_rsp[0].valid, wr_rsp[0].done}), 64'b11);
    idle(); rd_req[1] = '{addr: 5'd0, en: 1'b1}; cycle();
    chk("x0_data", 64'(rd_rsp[1].data), 64'd0);
    chk("x0_valid", 64'(rd_rsp[1].valid), 64'd1);

    // Claim, then bypassed write clears the pending bit
    idle(); claim_en = 1'b1; claim_rd = 5'd7; cycle();
    idle(); rd_req[0] = '{addr: 5'd7, en: 1'b1}; cycle();
    chk("x7_busy_valid", 64'(rd_rsp[0].valid), 64'd0);
    chk("busy7_set", 64'(busy[7]), 64'd1);
    idle();
    wr_req[0] = '{addr: 5'd7, data: 32'h55, en: 1'b1};
    rd_req[0] = '{addr: 5'd7, en: 1'b1};
    cycle();
    chk("x7_bypass_data", 64'(rd_rsp[0].data), 64'h55);
    chk("x7_bypass_valid", 64'(rd_rsp[0].valid), 64'd1);
    chk("busy7_clear", 64'(busy[7]), 64'd0);

    // Claim beats a same-cycle write; flush keeps contents
    idle(); claim_en = 1'b1; claim_rd = 5'd9;
    wr_req[1] = '{addr: 5'd9, data: 32'hA, en: 1'b1}; cycle();
    chk("busy9_claim_wins", 64'(busy[9]), 64'd1);
    idle(); rd_req[1] = '{addr: 5'd9, en: 1'b1}; cycle();
    chk("x9_data", 64'(rd_rsp[1].data), 64'hA);
    idle(); flush = 1'b1; claim_en = 1'b1; claim_rd = 5'd4; cycle();
    chk("flush_busy", 64'(busy), 64'd0);
    idle(); rd_req[1] = '{addr: 5'd9, en: 1'b1}; cycle();
    chk("x9_after_flush", 64'({rd_rsp[1].data, rd_rsp[1].valid}), 64'({32'hA, 1'b1}));

    // Write collision: port 1 wins
    idle();
    wr_req[0] = '{addr: 5'd3, data: 32'h11, en: 1'b1};
    wr_req[1] = '{addr: 5'd3, data: 32'h22, en: 1'b1};
    cycle();
    chk("coll_wr0", 64'({wr_rsp[0].valid, wr_rsp[0].done}), 64'b01);
    chk("coll_wr1", 64'({wr_rsp[1].valid, wr_rsp[1].done}), 64'b11);
    idle(); rd_req[0] = '{addr: 5'd3, en: 1'b1}; cycle();
    chk("x3_data", 64'(rd_rsp[0].data), 64'h22);

    // Randomized traffic over a narrow address range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NRd; i++) begin
        rd_req[i].en   = $urandom_range(0, 3) != 0;
        rd_req[i].addr = reg_addr_t'($urandom_range(0, 7));
      end
      for (int j = 0; j < NWr; j++) begin
        wr_req[j].en   = $urandom_range(0, 1) != 0;
        wr_req[j].addr = reg_addr_t'($urandom_range(0, 7));
        wr_req[j].data = $urandom;
      end
      claim_en = $urandom_range(0, 2) == 0;
      claim_rd = reg_addr_t'($urandom_range(0, 7));
      flush    = $urandom_range(0, 15) == 0;
      cycle();
    end

    // Asynchronous reset while a read is pending
    idle(); rd_req[0] = '{addr: 5'd3, en: 1'b1}; cycle();
    rd_req[0] = '{addr: 5'd5, en: 1'b1};
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rd0", 64'(rd_rsp[0]), 64'd0);
    chk("async_rd1", 64'(rd_rsp[1]), 64'd0);
    chk("async_wr", 64'(wr_rsp), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    rd_req[0] = '{addr: 5'd3, en: 1'b1};
    rd_req[1] = '{addr: 5'd9, en: 1'b1};
    cycle();
    chk("post_rst_x3", 64'(rd_rsp[0].data), 64'd0);
    chk("post_rst_x9", 64'(rd_rsp[1].data), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
